sa_os_engine: RTL

SA_OS_ENGINE -- requirements
Module: sa_os_engine

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_mac_pe.sv | 62 ++++++
 rtl/sa_os_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared constants and FSM state type for the output-stationary systolic engine.
package sa_pkg;

  localparam int unsigned DEF_D_W   = 16;
  localparam int unsigned DEF_FRAC  = 13;
  localparam int unsigned DEF_ACC_W = 32;

  localparam logic [DEF_D_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DEF_D_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush,
    StDrain
  } sa_state_e;

endpackage

// File: rtl/sa_mac_pe.sv
// Output-stationary MAC cell: forwards X right and W down, accumulates when both tags are set.
module sa_mac_pe import sa_pkg::*; #(
  parameter int unsigned D_W   = DEF_D_W,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [D_W-1:0]   x_i,
  input  logic             xv_i,
  input  logic [D_W-1:0]   w_i,
  input  logic             wv_i,
  output logic [D_W-1:0]   x_o,
  output logic             xv_o,
  output logic [D_W-1:0]   w_o,
  output logic             wv_o,
  output logic [ACC_W-1:0] acc_o
);

  logic [D_W-1:0]          x_q, w_q;
  logic                    xv_q, wv_q;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [2*D_W-1:0] prod;
  logic signed [ACC_W-1:0] incr;

  assign prod = $signed(x_i) * $signed(w_i);
  // Arithmetic shift drops the extra fraction bits; the cast sign-extends into the accumulator.
  assign incr = ACC_W'(prod >>> FRAC);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (xv_i && wv_i) begin
      acc_d = acc_q + incr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      w_q   <= '0;
      xv_q  <= 1'b0;
      wv_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      x_q   <= x_i;
      w_q   <= w_i;
      xv_q  <= xv_i;
      wv_q  <= wv_i;
      acc_q <= acc_d;
    end
  end

  assign x_o   = x_q;
  assign xv_o  = xv_q;
  assign w_o   = w_q;
  assign wv_o  = wv_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/sa_os_engine.sv
// S x C output-stationary systolic matrix engine: skewed X/W feed, free-running array,
// row-by-row saturated drain.
module sa_os_engine import sa_pkg::*; #(
  parameter int unsigned D_W   = DEF_D_W,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter int unsigned S     = 16,
  parameter int unsigned C     = 16,
  parameter int unsigned K_W   = 8,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_N,
  input  logic                 I_START,
  input  logic [K_W-1:0]       I_K,
  input  logic                 I_ACC,
  input  logic                 I_X_VLD,
  output logic                 O_X_RDY,
  input  logic [S*D_W-1:0]     I_X,
  input  logic [C*D_W-1:0]     I_W,
  output logic                 O_BUSY,
  output logic                 O_OUT_VLD,
  input  logic                 I_OUT_RDY,
  output logic [C*D_W-1:0]     O_OUT_ROW,
  output logic [$clog2(S)-1:0] O_OUT_IDX,
  output logic                 O_DONE
);

  localparam int unsigned IDX_W = $clog2(S);
  localparam int unsigned FL_W  = $clog2(S + C);

  localparam logic signed [ACC_W-1:0] AccMax = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = ~AccMax;
  localparam logic [D_W-1:0] SatHi = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [D_W-1:0] SatLo = {1'b1, {(D_W-1){1'b0}}};

  sa_state_e        state_q;
  logic [K_W-1:0]   cnt_q;
  logic [FL_W-1:0]  flush_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic             beat, clr;

  assign beat = (state_q == StLoad) && I_X_VLD;
  assign clr  = (state_q == StIdle) && I_START && !I_ACC;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      flush_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (I_START) begin
            cnt_q   <= I_K;
            idx_q   <= '0;
            state_q <= (I_K == '0) ? StDrain : StLoad;
          end
        end
        StLoad: begin
          if (I_X_VLD) begin
            cnt_q <= cnt_q - K_W'(1);
            if (cnt_q == K_W'(1)) begin
              state_q <= StFlush;
              flush_q <= FL_W'(S + C - 2);
            end
          end
        end
        StFlush: begin
          if (flush_q == '0) begin
            state_q <= StDrain;
            idx_q   <= '0;
          end else begin
            flush_q <= flush_q - FL_W'(1);
          end
        end
        StDrain: begin
          if (I_OUT_RDY) begin
            if (idx_q == IDX_W'(S - 1)) begin
              state_q <= StIdle;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign O_X_RDY   = (state_q == StLoad);
  assign O_BUSY    = (state_q != StIdle);
  assign O_OUT_VLD = (state_q == StDrain);
  assign O_OUT_IDX = idx_q;
  assign O_DONE    = done_q;

  // Array edges: x_h[i][j] feeds PE(i,j) from the left, w_v[i][j] feeds it from above.
  logic [D_W-1:0]   x_h  [S][C+1];
  logic             xv_h [S][C+1];
  logic [D_W-1:0]   w_v  [S+1][C];
  logic             wv_v [S+1][C];
  logic [ACC_W-1:0] acc  [S][C];

  for (genvar gi = 0; gi < S; gi++) begin : g_xskew
    logic [D_W:0] x_src;
    assign x_src = beat ? {1'b1, I_X[gi*D_W +: D_W]} : '0;
    if (gi == 0) begin : g_direct
      assign {xv_h[gi][0], x_h[gi][0]} = x_src;
    end else begin : g_delay
      logic [D_W:0] dl_q [gi];
      always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
          for (int k = 0; k < gi; k++) dl_q[k] <= '0;
        end else begin
          dl_q[0] <= x_src;
          for (int k = 1; k < gi; k++) dl_q[k] <= dl_q[k-1];
        end
      end
      assign {xv_h[gi][0], x_h[gi][0]} = dl_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < C; gj++) begin : g_wskew
    logic [D_W:0] w_src;
    assign w_src = beat ? {1'b1, I_W[gj*D_W +: D_W]} : '0;
    if (gj == 0) begin : g_direct
      assign {wv_v[0][gj], w_v[0][gj]} = w_src;
    end else begin : g_delay
      logic [D_W:0] dl_q [gj];
      always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
          for (int k = 0; k < gj; k++) dl_q[k] <= '0;
        end else begin
          dl_q[0] <= w_src;
          for (int k = 1; k < gj; k++) dl_q[k] <= dl_q[k-1];
        end
      end
      assign {wv_v[0][gj], w_v[0][gj]} = dl_q[gj-1];
    end
  end

  for (genvar gi = 0; gi < S; gi++) begin : g_row
    for (genvar gj = 0; gj < C; gj++) begin : g_col
      sa_mac_pe #(
        .D_W  (D_W),
        .FRAC (FRAC),
        .ACC_W(ACC_W)
      ) u_pe (
        .clk_i (I_CLK),
        .rst_ni(I_RST_N),
        .clr_i (clr),
        .x_i   (x_h[gi][gj]),
        .xv_i  (xv_h[gi][gj]),
        .w_i   (w_v[gi][gj]),
        .wv_i  (wv_v[gi][gj]),
        .x_o   (x_h[gi][gj+1]),
        .xv_o  (xv_h[gi][gj+1]),
        .w_o   (w_v[gi+1][gj]),
        .wv_o  (wv_v[gi+1][gj]),
        .acc_o (acc[gi][gj])
      );
    end
  end

  // Outputs of the far-edge PEs leave the array unused.
  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < S; i++) unused_edge = unused_edge ^ (^x_h[i][C]) ^ xv_h[i][C];
    for (int j = 0; j < C; j++) unused_edge = unused_edge ^ (^w_v[S][j]) ^ wv_v[S][j];
  end

  always_comb begin
    logic signed [ACC_W-1:0] sel;
    logic [D_W-1:0]          lane;
    O_OUT_ROW = '0;
    for (int j = 0; j < C; j++) begin
      sel = acc[idx_q][j];
      if (sel > AccMax)      lane = SatHi;
      else if (sel < AccMin) lane = SatLo;
      else                   lane = sel[D_W-1:0];
      if (O_OUT_VLD) O_OUT_ROW[j*D_W +: D_W] = lane;
    end
  end

endmodule
